fir_mac_sequencer: RTL and testbench
====================================

Name: fir_mac_sequencer

Overview:
- Time-multiplexed FIR filter controller that shares one signed 4x4 Baugh-Wooley multiplier across all taps.
- Accepts one 4-bit signed sample per valid/ready handshake and shifts it into a tap delay line.
- Steps the shared multiplier through NTAPS multiply-accumulate cycles, then presents the filtered result behind an output valid/ready handshake.
- Sits between the sample source and the filter output stage; coefficients are programmable through a small configuration port.

Parameters:
- NTAPS, 4, number of taps; delay-line depth and MAC cycles per sample; legal range 2..8.
- DW, 4, sample and coefficient width, two's complement; fixed by the shared multiplier.
- ACC_W, 10, accumulator and y_out width; must be at least 2*DW + clog2(NTAPS).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset; release is synchronised by the system.
- x_in  in  DW  input sample, signed.
- in_valid  in  1  x_in is valid.
- in_ready  out  1  block can accept a sample.
- cfg_we  in  1  coefficient write strobe.
- cfg_addr  in  3  coefficient index, 0..NTAPS-1.
- cfg_data  in  DW  coefficient value, signed.
- y_out  out  ACC_W  filter result, signed.
- out_valid  out  1  y_out is valid.
- out_ready  in  1  downstream accepts y_out.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; delay line d[0..NTAPS-1]=0; accumulator=0; tap counter=0.
  - y_out=0, out_valid=0, in_ready=1 after release, busy=0.
  - Coefficients reset to c[0]=1, all others 0, giving passthrough.
  - Reset asserted mid-operation aborts the computation immediately; no partial result is emitted.
- FSM: IDLE -> MAC -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid: shift the delay line (d[k]<=d[k-1], d[0]<=x_in), clear the accumulator, set tap counter=0, go to MAC.
- MAC:
  - One tap per cycle: acc <= acc + sext(c[t]*d[t]), using the shared multiplier product (2*DW bits, signed) sign-extended to ACC_W.
  - t increments each cycle. After t=NTAPS-1, load y_out with the final sum, set out_valid=1, go to DONE.
- DONE:
  - out_valid=1; y_out held stable.
  - On out_ready: out_valid<=0, go to IDLE.
  - in_ready stays 0 until IDLE is reached, so no new sample is taken on the same cycle as the output handshake.
- Latency: input handshake at edge N -> out_valid high after edge N+NTAPS. Throughput is one sample per NTAPS+2 cycles when out_ready is tied high.
- in_ready is 0 in MAC and DONE. in_valid in those states is ignored and the sample is not consumed.
- Output backpressure: the block stalls indefinitely in DONE, holding y_out and out_valid.
- Configuration:
  - cfg_we is honoured only in IDLE, written at the next edge.
  - Writes in MAC or DONE are dropped, and cfg_addr >= NTAPS is dropped; coefficients never change during a computation.
  - When cfg_we and in_valid arrive in the same IDLE cycle, the write lands at the same edge and the new coefficient is used for that sample.
- Arithmetic:
  - No saturation; the ACC_W sizing guarantees no overflow.
  - Worst case is (-8)*(-8)*NTAPS = 256 at the defaults.

Decomposition:
- Shared package fir_pkg:
  - state encoding constants S_IDLE, S_MAC, S_DONE;
  - defaults DW=4 and NTAPS=4;
  - coefficient reset values.
- One sub-module, bw_mult4: combinational signed 4x4 -> 8 Baugh-Wooley multiplier, instantiated once.
- FSM, delay line, coefficient registers and accumulator live in fir_mac_sequencer.

Test Plan:
- Reset passthrough: release rst_n, send x_in=3 -> out_valid after 4 MAC cycles, y_out=3; next sample -2 -> y_out=-2.
- Programmed taps: write c={1,2,-1,3}, then send 3, 1, 2 with out_ready=1 -> y_out = 3, 7, 1 in order; 6 cycles between handshakes.
- Extremes: all coefficients -8, four samples of -8 -> outputs 64, 128, 192, 256; no wrap.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 -> y_out and out_valid stable, in_ready=0, no sample consumed. Release -> the pending sample is accepted only after IDLE is reached.
- Config while busy: cfg_we in MAC writing c[0]=5 -> ignored, result unchanged. The same write in IDLE takes effect on the next sample.
- Reset mid-MAC: pull rst_n low at tap 2 -> out_valid=0 and y_out=0 immediately. Delay line cleared and coefficients back to passthrough; next sample 4 -> y_out=4.

Source files
------------

// File: rtl/fir_mac_sequencer_pkg.sv
// Shared definitions for the time-multiplexed FIR MAC sequencer:
// state encoding, default widths and coefficient reset values.
package fir_pkg;

  localparam int FIR_DW    = 4;
  localparam int FIR_NTAPS = 4;
  localparam int FIR_ACC_W = 10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Passthrough: only tap 0 contributes after reset.
  function automatic logic signed [FIR_DW-1:0] coef_reset(input int k);
    return (k == 0) ? FIR_DW'(1) : '0;
  endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Sample input, coefficient configuration and result output of the FIR sequencer.
interface fir_mac_sequencer_if
  import fir_pkg::*;
#(
  parameter int DW    = FIR_DW,
  parameter int ACC_W = FIR_ACC_W
);
  // Both streams transfer on a rising edge where valid and ready are both high;
  // valid never waits for ready, and a source holds its data while valid is
  // high and ready is low.
  logic signed [DW-1:0]    x_in;
  logic                    in_valid;
  logic                    in_ready;
  logic                    cfg_we;
  logic [2:0]              cfg_addr;
  logic signed [DW-1:0]    cfg_data;
  logic signed [ACC_W-1:0] y_out;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output x_in, in_valid, cfg_we, cfg_addr, cfg_data, out_ready,
    input  in_ready, y_out, out_valid
  );

  modport slave (
    input  x_in, in_valid, cfg_we, cfg_addr, cfg_data, out_ready,
    output in_ready, y_out, out_valid
  );

endinterface

// File: rtl/fir_mac_sequencer_bw_mult4.sv
// Combinational signed 4x4 -> 8 Baugh-Wooley multiplier shared by all FIR taps.
module bw_mult4 (
  input  logic signed [3:0] i_a,
  input  logic signed [3:0] i_b,
  output logic signed [7:0] o_p
);

  logic [7:0] w_sum;
  logic       w_pp;

  // Partial products touching exactly one sign bit are inverted; the two
  // correction ones at weights 2^4 and 2^7 start the sum.
  always_comb begin
    w_sum = 8'b1001_0000;
    w_pp  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        w_pp = i_a[i] & i_b[j];
        if ((i == 3) != (j == 3)) w_pp = ~w_pp;
        w_sum = w_sum + (8'(w_pp) << (i + j));
      end
    end
  end

  assign o_p = w_sum;

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR controller: one sample in, NTAPS multiply-accumulate cycles through a
// single shared multiplier, one result out.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int NTAPS = FIR_NTAPS,
  parameter int DW    = FIR_DW,
  parameter int ACC_W = FIR_ACC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  fir_mac_sequencer_if.slave bus,
  output logic               busy,
  output state_t             o_dbg_state
);

  localparam int            TW       = $clog2(NTAPS);
  localparam logic [TW-1:0] LAST_TAP = TW'(NTAPS - 1);

  state_t                  r_state;
  logic signed [DW-1:0]    r_d    [NTAPS];
  logic signed [DW-1:0]    r_coef [NTAPS];
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_y;
  logic [TW-1:0]           r_tap;
  logic                    r_out_valid;
  logic                    r_in_ready;
  logic                    r_busy;

  logic signed [2*DW-1:0]  w_prod;
  logic signed [ACC_W-1:0] w_acc_next;
  logic                    w_cfg_hit;

  bw_mult4 u_mult (
    .i_a (r_coef[r_tap]),
    .i_b (r_d[r_tap]),
    .o_p (w_prod)
  );

  assign w_acc_next = r_acc + ACC_W'(w_prod);
  assign w_cfg_hit  = bus.cfg_we && (int'(bus.cfg_addr) < NTAPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_y         <= '0;
      r_tap       <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      for (int k = 0; k < NTAPS; k++) begin
        r_d[k]    <= '0;
        r_coef[k] <= DW'(coef_reset(k));
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          // Coefficient writes land only here, so a same-cycle sample sees them.
          if (w_cfg_hit) r_coef[bus.cfg_addr[TW-1:0]] <= bus.cfg_data;
          if (bus.in_valid) begin
            for (int k = NTAPS - 1; k > 0; k--) r_d[k] <= r_d[k-1];
            r_d[0]     <= bus.x_in;
            r_acc      <= '0;
            r_tap      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_MAC;
          end
        end
        S_MAC: begin
          if (r_tap == LAST_TAP) begin
            r_y         <= w_acc_next;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_acc <= w_acc_next;
            r_tap <= r_tap + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.y_out     = r_y;
  assign busy          = r_busy;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: directed scenarios plus random traffic checked
// against an arithmetic FIR model (delay line and coefficient arrays).
module tb_fir_mac_sequencer;
  import fir_pkg::*;

  localparam int NTAPS = 4;
  localparam int DW    = 4;
  localparam int ACC_W = 10;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   busy;
  state_t dbg_state;
  int     cyc = 0;

  fir_mac_sequencer_if #(.DW(DW), .ACC_W(ACC_W)) bus ();

  fir_mac_sequencer #(.NTAPS(NTAPS), .DW(DW), .ACC_W(ACC_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int c_m [NTAPS];
  int d_m [NTAPS];
  logic [31:0] exp_q [$];

  bit stage_cfg = 0;
  int stage_a   = 0;
  int stage_d   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NTAPS; k++) begin
      c_m[k] = (k == 0) ? 1 : 0;
      d_m[k] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_cfg(input int a, input int d);
    if (a < NTAPS) c_m[a] = d;
  endtask

  task automatic model_accept(input int x);
    int sum;
    for (int k = NTAPS - 1; k > 0; k--) d_m[k] = d_m[k-1];
    d_m[0] = x;
    sum = 0;
    for (int k = 0; k < NTAPS; k++) sum += c_m[k] * d_m[k];
    exp_q.push_back(32'(sum));
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.cfg_we = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic cfg_write(input int a, input int d);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 3'(a);
    bus.cfg_data = DW'(d);
    @(posedge clk);
    #1 bus.cfg_we = 1'b0;
    model_cfg(a, d);
  endtask

  // Offer a sample (optionally with a staged coefficient write) and complete its handshake.
  task automatic start_sample(input int x, output int hs_cyc);
    int n;
    bus.x_in = DW'(x);
    bus.in_valid = 1'b1;
    if (stage_cfg) begin
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 3'(stage_a);
      bus.cfg_data = DW'(stage_d);
    end
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 100) check("in_ready timeout", 0, 1);
    @(posedge clk);
    #1 hs_cyc = cyc;
    if (stage_cfg) model_cfg(stage_a, stage_d);
    model_accept(x);
    stage_cfg = 0;
    bus.cfg_we = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  // Wait for the result, optionally poke config during MAC and/or hold off out_ready.
  task automatic finish_sample(input int hold, input bit pend, input int pend_x, input bit poke);
    int lat;
    int y_first;
    lat = 0;
    bus.in_valid = 1'b1;
    bus.x_in = DW'($urandom_range(15, 0));
    if (poke) begin
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 3'd0;
      bus.cfg_data = DW'(5);
    end
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk);
      #1 lat++;
      if (lat == 2) bus.cfg_we = 1'b0;
    end
    bus.cfg_we = 1'b0;
    check("latency", lat, NTAPS);
    check("busy in DONE", int'(busy), 1);
    y_first = int'($signed(bus.y_out));
    if (exp_q.size() > 0) check("y_out", y_first, int'($signed(exp_q.pop_front())));
    else check("unexpected result", 1, 0);
    if (pend) bus.x_in = DW'(pend_x);
    else bus.in_valid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold out_valid", int'(bus.out_valid), 1);
      check("hold y_out", int'($signed(bus.y_out)), y_first);
      check("hold in_ready", int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    if (!pend) bus.in_valid = 1'b0;
    check("out_valid drop", int'(bus.out_valid), 0);
    check("in_ready idle", int'(bus.in_ready), 1);
    check("busy idle", int'(busy), 0);
  endtask

  task automatic do_sample(input int x, input int hold);
    int hs;
    start_sample(x, hs);
    finish_sample(hold, 1'b0, 0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hs, prev_hs;
    int coefs [NTAPS];
    bus.x_in = '0;
    bus.in_valid = 1'b0;
    bus.cfg_we = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    bus.out_ready = 1'b0;

    do_reset();
    check("rst out_valid", int'(bus.out_valid), 0);
    check("rst y_out", int'($signed(bus.y_out)), 0);
    check("rst in_ready", int'(bus.in_ready), 1);
    check("rst busy", int'(busy), 0);
    check("rst state", int'(dbg_state), int'(S_IDLE));

    // Passthrough coefficients from reset.
    do_sample(3, 0);
    do_sample(-2, 0);

    // Programmed taps with out_ready high: fixed handshake spacing.
    do_reset();
    coefs = '{1, 2, -1, 3};
    for (int k = 0; k < NTAPS; k++) cfg_write(k, coefs[k]);
    start_sample(3, hs);
    finish_sample(0, 1'b0, 0, 1'b0);
    prev_hs = hs;
    start_sample(1, hs);
    check("gap", hs - prev_hs, NTAPS + 2);
    finish_sample(0, 1'b0, 0, 1'b0);
    prev_hs = hs;
    start_sample(2, hs);
    check("gap", hs - prev_hs, NTAPS + 2);
    finish_sample(0, 1'b0, 0, 1'b0);

    // Extremes: largest magnitude products, no wrap.
    do_reset();
    for (int k = 0; k < NTAPS; k++) cfg_write(k, -8);
    for (int i = 0; i < NTAPS; i++) do_sample(-8, 0);

    // Backpressure with a pending sample offered throughout DONE.
    start_sample(5, hs);
    finish_sample(10, 1'b1, -3, 1'b0);
    do_sample(-3, 0);

    // Config write during MAC is dropped; the same write in IDLE takes effect.
    do_reset();
    start_sample(2, hs);
    finish_sample(0, 1'b0, 0, 1'b1);
    cfg_write(0, 5);
    do_sample(1, 0);

    // Write and sample in the same IDLE cycle.
    stage_cfg = 1;
    stage_a = 1;
    stage_d = -3;
    do_sample(6, 0);

    // Reset in the middle of MAC.
    start_sample(7, hs);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort out_valid", int'(bus.out_valid), 0);
    check("abort y_out", int'($signed(bus.y_out)), 0);
    check("abort busy", int'(busy), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_sample(4, 0);
    for (int k = 0; k < NTAPS; k++) cfg_write(k, 1);
    do_sample(1, 0);

    // Random traffic: writes (including out-of-range addresses), samples, holds.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1, 0) == 1)
        cfg_write(int'($urandom_range(7, 0)), int'($urandom_range(15, 0)) - 8);
      if ($urandom_range(3, 0) == 0) begin
        stage_cfg = 1;
        stage_a = int'($urandom_range(7, 0));
        stage_d = int'($urandom_range(15, 0)) - 8;
      end
      do_sample(int'($urandom_range(15, 0)) - 8, int'($urandom_range(3, 0)));
    end

    check("queue drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
